// File: rtl/rapid_pkg.sv
// Shared types and constants for the rapid in-order pipeline.
// control_s is the decode-to-execute control bundle.
package rapid_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       funct7_5;
        logic       alu_imm;
        logic       alu_reg;
        logic       mem;
        logic       iop;
        logic       cond_branch;
        logic       uncond_branch;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic       reg_write;
        logic       illegal;
    } control_s;

endpackage

// File: rtl/rapid_instruction_decoder.sv
// RV32I decode stage: combinational decode of the fetched word, registered
// control bundle, immediate and PC, updated on each pipeline advance.
module rapid_instruction_decoder
    import rapid_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_instruction,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pipeline_ready,
    output logic [XLEN-1:0] o_pc,
    output control_s        o_control_signal,
    output logic [XLEN-1:0] o_imm,
    output logic            o_done
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0]      w_opcode;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm;
    logic            w_writes_rd;
    control_s        w_ctrl;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    control_s        r_ctrl;
    logic            r_done;

    assign w_opcode = i_instruction[6:0];

    // Immediate formats, all sign-extended from bit 31
    assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign w_imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                      i_instruction[30:25], i_instruction[11:8], 1'b0};
    assign w_imm_u = {i_instruction[31:12], 12'b0};
    assign w_imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                      i_instruction[20], i_instruction[30:21], 1'b0};

    always_comb begin
        w_ctrl          = '0;
        w_imm           = '0;
        w_writes_rd     = 1'b0;

        w_ctrl.rd       = i_instruction[11:7];
        w_ctrl.rs1      = i_instruction[19:15];
        w_ctrl.rs2      = i_instruction[24:20];
        w_ctrl.funct3   = i_instruction[14:12];
        w_ctrl.funct7_5 = i_instruction[30];

        case (w_opcode)
            OPC_OP_IMM: begin
                w_ctrl.alu_imm = 1'b1;
                w_writes_rd    = 1'b1;
                w_imm          = w_imm_i;
            end
            OPC_OP: begin
                w_ctrl.alu_reg = 1'b1;
                w_writes_rd    = 1'b1;
            end
            OPC_LOAD: begin
                w_ctrl.mem     = 1'b1;
                w_ctrl.iop     = 1'b1;
                w_writes_rd    = 1'b1;
                w_imm          = w_imm_i;
            end
            OPC_STORE: begin
                w_ctrl.mem     = 1'b1;
                w_imm          = w_imm_s;
            end
            OPC_BRANCH: begin
                w_ctrl.cond_branch = 1'b1;
                w_imm              = w_imm_b;
            end
            OPC_JAL: begin
                w_ctrl.uncond_branch = 1'b1;
                w_writes_rd          = 1'b1;
                w_imm                = w_imm_j;
            end
            OPC_JALR: begin
                w_ctrl.uncond_branch = 1'b1;
                w_ctrl.jalr          = 1'b1;
                w_writes_rd          = 1'b1;
                w_imm                = w_imm_i;
            end
            OPC_LUI: begin
                w_ctrl.lui     = 1'b1;
                w_writes_rd    = 1'b1;
                w_imm          = w_imm_u;
            end
            OPC_AUIPC: begin
                w_ctrl.auipc   = 1'b1;
                w_writes_rd    = 1'b1;
                w_imm          = w_imm_u;
            end
            default: begin
                w_ctrl.illegal = 1'b1;
            end
        endcase

        // Writes to x0 are dropped here so later stages never see them
        w_ctrl.reg_write = w_writes_rd && (w_ctrl.rd != 5'd0);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc   <= '0;
            r_imm  <= '0;
            r_ctrl <= '0;
            r_done <= 1'b0;
        end else if (i_pipeline_ready) begin
            r_pc   <= i_pc;
            r_imm  <= w_imm;
            r_ctrl <= w_ctrl;
            r_done <= 1'b1;
        end
    end

    assign o_pc             = r_pc;
    assign o_imm            = r_imm;
    assign o_control_signal = r_ctrl;
    assign o_done           = r_done;

endmodule

// File: tb/tb_rapid_instruction_decoder.sv
// Directed self-checking bench for rapid_instruction_decoder.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_rapid_instruction_decoder;
    import rapid_pkg::*;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [XLEN-1:0] i_instruction;
    logic [XLEN-1:0] i_pc;
    logic            i_pipeline_ready;
    logic [XLEN-1:0] o_pc;
    control_s        o_control_signal;
    logic [XLEN-1:0] o_imm;
    logic            o_done;

    int n_cmp = 0;
    int n_bad = 0;

    rapid_instruction_decoder dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_instruction    (i_instruction),
        .i_pc             (i_pc),
        .i_pipeline_ready (i_pipeline_ready),
        .o_pc             (o_pc),
        .o_control_signal (o_control_signal),
        .o_imm            (o_imm),
        .o_done           (o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic control_s mk(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3,
                                    input logic f75);
        control_s c;
        c          = '0;
        c.rd       = rd;
        c.rs1      = rs1;
        c.rs2      = rs2;
        c.funct3   = f3;
        c.funct7_5 = f75;
        return c;
    endfunction

    task automatic drive_edge(input logic [31:0] instr, input logic [31:0] pc, input logic rdy);
        @(negedge i_clk);
        i_instruction    = instr;
        i_pc             = pc;
        i_pipeline_ready = rdy;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset          = 1'b1;
        i_instruction    = 32'h00a00193;
        i_pc             = 32'h0000_1000;
        i_pipeline_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_control_signal !== control_s'('0) || o_imm !== 32'h0 || o_pc !== 32'h0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_held: ctrl=%h imm=%h pc=%h done=%b required all zero", o_control_signal, o_imm, o_pc, o_done);
        end
        @(negedge i_clk);
        i_reset          = 1'b0;
        i_pipeline_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            n_cmp++;
            if (o_control_signal !== control_s'('0) || o_imm !== 32'h0 || o_pc !== 32'h0 || o_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle_%0d: ctrl=%h imm=%h pc=%h done=%b required all zero", k, o_control_signal, o_imm, o_pc, o_done);
            end
        end
    endtask

    task automatic test_addi_hold();
        control_s e;
        e = mk(5'd3, 5'd0, 5'd10, 3'd0, 1'b0);
        e.alu_imm = 1'b1;
        e.reg_write = 1'b1;
        drive_edge(32'h00a00193, 32'h0000_0000, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'd10 || o_pc !== 32'h0 || o_done !== 1'b1) begin
            n_bad++;
            $display("FAIL addi: ctrl=%h imm=%h pc=%h done=%b required ctrl=%h imm=%h pc=0 done=1", o_control_signal, o_imm, o_pc, o_done, e, 32'd10);
        end
        drive_edge(32'hffffffff, 32'h0000_0044, 1'b0);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'd10 || o_pc !== 32'h0 || o_done !== 1'b1) begin
            n_bad++;
            $display("FAIL hold: ctrl=%h imm=%h pc=%h done=%b required ctrl=%h imm=%h pc=0 done=1", o_control_signal, o_imm, o_pc, o_done, e, 32'd10);
        end
    endtask

    task automatic test_mem();
        control_s e;
        e = mk(5'd5, 5'd2, 5'd28, 3'd2, 1'b1);
        e.mem = 1'b1;
        e.iop = 1'b1;
        e.reg_write = 1'b1;
        drive_edge(32'hffc12283, 32'h0000_0004, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'hFFFF_FFFC || o_pc !== 32'h4) begin
            n_bad++;
            $display("FAIL lw: ctrl=%h imm=%h pc=%h required ctrl=%h imm=fffffffc pc=4", o_control_signal, o_imm, o_pc, e);
        end
        e = mk(5'd8, 5'd1, 5'd6, 3'd2, 1'b0);
        e.mem = 1'b1;
        drive_edge(32'h0060a423, 32'h0000_0008, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'd8 || o_pc !== 32'h8) begin
            n_bad++;
            $display("FAIL sw: ctrl=%h imm=%h pc=%h required ctrl=%h imm=8 pc=8", o_control_signal, o_imm, o_pc, e);
        end
    endtask

    task automatic test_flow();
        control_s e;
        e = mk(5'd25, 5'd1, 5'd2, 3'd0, 1'b1);
        e.cond_branch = 1'b1;
        drive_edge(32'hfe208ce3, 32'h0000_0100, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'hFFFF_FFF8 || o_pc !== 32'h100) begin
            n_bad++;
            $display("FAIL beq: ctrl=%h imm=%h pc=%h required ctrl=%h imm=fffffff8 pc=100", o_control_signal, o_imm, o_pc, e);
        end
        e = mk(5'd1, 5'd0, 5'd16, 3'd0, 1'b0);
        e.uncond_branch = 1'b1;
        e.reg_write = 1'b1;
        drive_edge(32'h010000ef, 32'h0000_0104, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'd16 || o_pc !== 32'h104) begin
            n_bad++;
            $display("FAIL jal: ctrl=%h imm=%h pc=%h required ctrl=%h imm=10 pc=104", o_control_signal, o_imm, o_pc, e);
        end
        e = mk(5'd1, 5'd5, 5'd4, 3'd0, 1'b0);
        e.uncond_branch = 1'b1;
        e.jalr = 1'b1;
        e.reg_write = 1'b1;
        drive_edge(32'h004280e7, 32'h0000_0108, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'd4) begin
            n_bad++;
            $display("FAIL jalr: ctrl=%h imm=%h required ctrl=%h imm=4", o_control_signal, o_imm, e);
        end
        e = mk(5'd7, 5'd8, 5'd3, 3'd5, 1'b0);
        e.lui = 1'b1;
        e.reg_write = 1'b1;
        drive_edge(32'h123453b7, 32'h0000_010c, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'h1234_5000) begin
            n_bad++;
            $display("FAIL lui: ctrl=%h imm=%h required ctrl=%h imm=12345000", o_control_signal, o_imm, e);
        end
        e = mk(5'd10, 5'd31, 5'd31, 3'd7, 1'b1);
        e.auipc = 1'b1;
        e.reg_write = 1'b1;
        drive_edge(32'hfffff517, 32'h0000_0110, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'hFFFF_F000 || o_pc !== 32'h110) begin
            n_bad++;
            $display("FAIL auipc: ctrl=%h imm=%h pc=%h required ctrl=%h imm=fffff000 pc=110", o_control_signal, o_imm, o_pc, e);
        end
    endtask

    task automatic test_alu_reg();
        control_s e;
        e = mk(5'd3, 5'd1, 5'd2, 3'd0, 1'b1);
        e.alu_reg = 1'b1;
        e.reg_write = 1'b1;
        drive_edge(32'h402081b3, 32'h0000_0200, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'h0) begin
            n_bad++;
            $display("FAIL sub: ctrl=%h imm=%h required ctrl=%h imm=0", o_control_signal, o_imm, e);
        end
    endtask

    task automatic test_illegal_rd0();
        control_s e;
        e = mk(5'd31, 5'd31, 5'd31, 3'd7, 1'b1);
        e.illegal = 1'b1;
        drive_edge(32'hffffffff, 32'h0000_0300, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'h0 || o_done !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal: ctrl=%h imm=%h done=%b required ctrl=%h imm=0 done=1", o_control_signal, o_imm, o_done, e);
        end
        e = mk(5'd0, 5'd0, 5'd0, 3'd0, 1'b0);
        e.alu_imm = 1'b1;
        drive_edge(32'h00000013, 32'h0000_0304, 1'b1);
        n_cmp++;
        if (o_control_signal !== e || o_imm !== 32'h0 || o_pc !== 32'h304) begin
            n_bad++;
            $display("FAIL nop_rd0: ctrl=%h imm=%h pc=%h required ctrl=%h imm=0 pc=304", o_control_signal, o_imm, o_pc, e);
        end
    endtask

    task automatic test_back_to_back();
        control_s e1;
        control_s e2;
        e1 = mk(5'd5, 5'd2, 5'd28, 3'd2, 1'b1);
        e1.mem = 1'b1;
        e1.iop = 1'b1;
        e1.reg_write = 1'b1;
        e2 = mk(5'd3, 5'd0, 5'd10, 3'd0, 1'b0);
        e2.alu_imm = 1'b1;
        e2.reg_write = 1'b1;
        drive_edge(32'hffc12283, 32'h0000_0400, 1'b1);
        n_cmp++;
        if (o_control_signal !== e1 || o_imm !== 32'hFFFF_FFFC || o_pc !== 32'h400) begin
            n_bad++;
            $display("FAIL b2b_first: ctrl=%h imm=%h pc=%h required ctrl=%h imm=fffffffc pc=400", o_control_signal, o_imm, o_pc, e1);
        end
        drive_edge(32'h00a00193, 32'h0000_0404, 1'b1);
        n_cmp++;
        if (o_control_signal !== e2 || o_imm !== 32'd10 || o_pc !== 32'h404) begin
            n_bad++;
            $display("FAIL b2b_second: ctrl=%h imm=%h pc=%h required ctrl=%h imm=a pc=404", o_control_signal, o_imm, o_pc, e2);
        end
    endtask

    task automatic test_async_reset();
        drive_edge(32'h123453b7, 32'h0000_0500, 1'b1);
        @(negedge i_clk);
        i_pipeline_ready = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        n_cmp++;
        if (o_control_signal !== control_s'('0) || o_imm !== 32'h0 || o_pc !== 32'h0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: ctrl=%h imm=%h pc=%h done=%b required all zero", o_control_signal, o_imm, o_pc, o_done);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_done !== 1'b0 || o_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL post_reset_idle: done=%b pc=%h required done=0 pc=0", o_done, o_pc);
        end
    endtask

    initial begin
        test_reset();
        test_addi_hold();
        test_mem();
        test_flow();
        test_alu_reg();
        test_illegal_rd0();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
